// File: rtl/serial_fa_sched_if.sv
// Handshake and datapath bundle for serial_fa_sched.
// slave  : scheduler side (receives requests, drives the full adder, produces results)
// master : environment side (requesters, full_adder cell, result consumer)
// Optional subtract ports appear when SERIAL_FA_SCHED_SUB_EN is defined.
interface serial_fa_sched_if #(parameter int W = 8);
  logic         req0_valid, req0_ready, req0_ci;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_ci;
  logic [W-1:0] req1_a, req1_b;
`ifdef SERIAL_FA_SCHED_SUB_EN
  logic         req0_sub, req1_sub;
`endif
  logic         fa_a, fa_b, fa_ci, fa_sum, fa_co;
  logic         res_valid, res_ready, res_co, res_id;
  logic [W-1:0] res_sum;
  logic         busy;

  modport slave (
`ifdef SERIAL_FA_SCHED_SUB_EN
    input  req0_sub, req1_sub,
`endif
    input  req0_valid, req0_a, req0_b, req0_ci,
    input  req1_valid, req1_a, req1_b, req1_ci,
    input  fa_sum, fa_co, res_ready,
    output req0_ready, req1_ready, fa_a, fa_b, fa_ci,
    output res_valid, res_sum, res_co, res_id, busy
  );

  modport master (
`ifdef SERIAL_FA_SCHED_SUB_EN
    output req0_sub, req1_sub,
`endif
    output req0_valid, req0_a, req0_b, req0_ci,
    output req1_valid, req1_a, req1_b, req1_ci,
    output fa_sum, fa_co, res_ready,
    input  req0_ready, req1_ready, fa_a, fa_b, fa_ci,
    input  res_valid, res_sum, res_co, res_id, busy
  );
endinterface

// File: rtl/serial_fa_sched.sv
// Bit-serial add scheduler: round-robin between two requesters, drives one
// external combinational full adder LSB-first for W cycles, returns sum/carry
// on a valid/ready result port.
// Optional feature macro: SERIAL_FA_SCHED_SUB_EN (per-requester subtract).
//
// state | meaning
// IDLE  | waiting for a request, grant is combinational
// RUN   | one operand bit per cycle through the shared full adder
// DONE  | result presented, held until res_ready
module serial_fa_sched #(
  parameter int W = 8
) (
  input logic           clk,
  input logic           rst,
  serial_fa_sched_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          carry_q, carry_d, id_q, id_d, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          gnt_vld, gnt_id, acc_sub, acc_ci;
  logic [W-1:0]  acc_a, acc_b;
  logic          run, done;

  // Grant selection: single requester wins outright, contention alternates.
  always_comb begin
    gnt_vld = (state_q == S_IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    if (bus.req0_valid && bus.req1_valid) gnt_id = ~last_q;
    else                                  gnt_id = bus.req1_valid;
  end

  assign bus.req0_ready = gnt_vld & ~gnt_id;
  assign bus.req1_ready = gnt_vld &  gnt_id;

  // Operand mux from the granted requester; subtract is a ~b + 1 load.
  always_comb begin
    acc_a  = gnt_id ? bus.req1_a  : bus.req0_a;
    acc_b  = gnt_id ? bus.req1_b  : bus.req0_b;
    acc_ci = gnt_id ? bus.req1_ci : bus.req0_ci;
`ifdef SERIAL_FA_SCHED_SUB_EN
    acc_sub = gnt_id ? bus.req1_sub : bus.req0_sub;
`else
    acc_sub = 1'b0;
`endif
  end

  // Next-state and datapath for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          a_d     = acc_a;
          b_d     = acc_sub ? ~acc_b : acc_b;
          carry_d = acc_sub ? 1'b1 : acc_ci;
          id_d    = gnt_id;
          last_d  = gnt_id;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = {bus.fa_sum, sum_q[W-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bus.fa_co;
        // Hold the counter on the final bit so it never wraps.
        if (cnt_q == CW'(W - 1)) state_d = S_DONE;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      S_DONE: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  assign bus.fa_a      = run & a_q[0];
  assign bus.fa_b      = run & b_q[0];
  assign bus.fa_ci     = run & carry_q;
  assign bus.res_valid = done;
  assign bus.res_sum   = {W{done}} & sum_q;
  assign bus.res_co    = done & carry_q;
  assign bus.res_id    = done & id_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_serial_fa_sched.sv
// Directed bench for serial_fa_sched with a behavioural full adder cell.
module tb_serial_fa_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  serial_fa_sched_if #(.W(W)) bus ();

  serial_fa_sched #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External gate-level full adder, zero-delay.
  assign bus.fa_sum = bus.fa_a ^ bus.fa_b ^ bus.fa_ci;
  assign bus.fa_co  = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_ci) | (bus.fa_b & bus.fa_ci);

  always #5 clk = ~clk;

  // Issue one request, return the result seen at the first negedge with res_valid.
  // lat counts edges after the accept edge; fa_cnt counts RUN cycles with any fa_* high.
  task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit ci, input bit sub,
                        output logic [W-1:0] s, output bit co, output bit rid,
                        output int lat, output int fa_cnt, output bit tmo);
    int n;
    tmo = 1'b0; lat = 0; fa_cnt = 0; n = 0;
    @(negedge clk);
    if (!id) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_ci = ci;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_ci = ci;
    end
`ifdef SERIAL_FA_SCHED_SUB_EN
    bus.req0_sub = sub; bus.req1_sub = sub;
`else
    if (sub) $display("note: subtract requested in add-only build");
`endif
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) tmo = 1'b1;
    @(posedge clk); #1;
    // Scramble the inputs after acceptance; the operation must not notice.
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = ~a; bus.req0_b = ~b; bus.req0_ci = ~ci;
    bus.req1_a = ~a; bus.req1_b = ~b; bus.req1_ci = ~ci;
    while (!tmo) begin
      @(negedge clk);
      if (bus.res_valid) break;
      if (bus.fa_a | bus.fa_b | bus.fa_ci) fa_cnt++;
      @(posedge clk);
      lat++;
      if (lat > 100) tmo = 1'b1;
    end
    s = bus.res_sum; co = bus.res_co; rid = bus.res_id;
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit seen_valid;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({bus.req0_ready, bus.req1_ready, bus.fa_a, bus.fa_b, bus.fa_ci, bus.res_valid,
         bus.res_sum, bus.res_co, bus.res_id, bus.busy} !== '0) begin
      n_err++; $display("FAIL reset_outputs: some output nonzero (busy=%b res_valid=%b), required all 0", bus.busy, bus.res_valid);
    end
    rst = 1'b0;
    // Start traffic, then reset mid-RUN.
    bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h01; bus.req0_ci = 1'b0;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL reset_pre_busy: busy=%b required 1", bus.busy); end
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({bus.req0_ready, bus.req1_ready, bus.fa_a, bus.fa_b, bus.fa_ci, bus.res_valid,
         bus.res_sum, bus.res_co, bus.res_id, bus.busy} !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs: busy=%b res_valid=%b fa=%b%b%b, required all 0",
                        bus.busy, bus.res_valid, bus.fa_a, bus.fa_b, bus.fa_ci);
    end
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen_valid = 1'b1;
    end
    n_vec++;
    if (seen_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_result: res_valid seen=%b required 0", seen_valid); end
    // First contention after reset goes to requester 0.
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    n_vec++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      n_err++; $display("FAIL reset_first_grant: {r1,r0}=%b required 01", {bus.req1_ready, bus.req0_ready});
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_single_add();
    logic [W-1:0] s; bit co, rid, tmo; int lat, fac;
    @(negedge clk);
    n_vec++;
    if ({bus.fa_a, bus.fa_b, bus.fa_ci} !== 3'b000) begin n_err++; $display("FAIL add_fa_idle: fa=%b required 000", {bus.fa_a, bus.fa_b, bus.fa_ci}); end
    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, s, co, rid, lat, fac, tmo);
    n_vec++;
    if (tmo !== 1'b0) begin n_err++; $display("FAIL add_timeout: timeout=%b required 0", tmo); end
    n_vec++;
    if ({co, s, rid} !== {1'b0, 8'h96, 1'b0}) begin
      n_err++; $display("FAIL add_result: co=%b sum=%h id=%b required co=0 sum=96 id=0", co, s, rid);
    end
    // res_valid visible after edge T+W.
    n_vec++;
    if (lat !== W) begin n_err++; $display("FAIL add_latency: %0d edges required %0d", lat, W); end
    // 0x5A/0x3C: bit 0 has a=b=ci=0, the other 7 bits drive something.
    n_vec++;
    if (fac !== 7) begin n_err++; $display("FAIL add_fa_activity: %0d active RUN cycles required 7", fac); end
    n_vec++;
    if ({bus.fa_a, bus.fa_b, bus.fa_ci} !== 3'b000) begin n_err++; $display("FAIL add_fa_done: fa=%b required 000", {bus.fa_a, bus.fa_b, bus.fa_ci}); end
    take_result();
  endtask

  task automatic test_carry();
    logic [W-1:0] s; bit co, rid, tmo; int lat, fac;
    run_op(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, s, co, rid, lat, fac, tmo);
    n_vec++;
    if (tmo !== 1'b0 || {co, s, rid} !== {1'b1, 8'h00, 1'b1}) begin
      n_err++; $display("FAIL carry_ff_01: tmo=%b co=%b sum=%h id=%b required co=1 sum=00 id=1", tmo, co, s, rid);
    end
    take_result();
    run_op(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, s, co, rid, lat, fac, tmo);
    n_vec++;
    if (tmo !== 1'b0 || {co, s, rid} !== {1'b1, 8'hFF, 1'b1}) begin
      n_err++; $display("FAIL carry_ff_ff_1: tmo=%b co=%b sum=%h id=%b required co=1 sum=ff id=1", tmo, co, s, rid);
    end
    take_result();
  endtask

  task automatic test_arbitration();
    bit           g_id [4];
    int           g_cyc [4];
    bit           r_id [4];
    bit           r_co [4];
    logic [W-1:0] r_sum [4];
    int ng, nr, cyc, both;
    ng = 0; nr = 0; cyc = 0; both = 0;
    @(negedge clk);
    bus.res_ready = 1'b1;
    bus.req0_a = 8'h12; bus.req0_b = 8'h34; bus.req0_ci = 1'b0;
    bus.req1_a = 8'h80; bus.req1_b = 8'h90; bus.req1_ci = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    while (nr < 4 && cyc < 200) begin
      #1;
      cyc++;
      if (bus.req0_ready && bus.req1_ready) both++;
      if (bus.res_valid) begin
        r_id[nr] = bus.res_id; r_co[nr] = bus.res_co; r_sum[nr] = bus.res_sum; nr++;
      end
      if ((bus.req0_ready || bus.req1_ready) && ng < 4) begin
        g_id[ng] = bus.req1_ready; g_cyc[ng] = cyc; ng++;
        if (ng == 4) begin
          @(posedge clk); #1;
          bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    n_vec++;
    if (nr !== 4) begin n_err++; $display("FAIL arb_results: %0d results required 4", nr); end
    n_vec++;
    if (both !== 0) begin n_err++; $display("FAIL arb_both_ready: %0d cycles required 0", both); end
    n_vec++;
    if ({g_id[0], g_id[1], g_id[2], g_id[3]} !== 4'b0101) begin
      n_err++; $display("FAIL arb_order: grants=%b%b%b%b required 0101", g_id[0], g_id[1], g_id[2], g_id[3]);
    end
    n_vec++;
    if (g_cyc[1] - g_cyc[0] !== W + 2) begin
      n_err++; $display("FAIL arb_throughput: spacing %0d required %0d", g_cyc[1] - g_cyc[0], W + 2);
    end
    for (int i = 0; i < nr; i++) begin
      n_vec++;
      if (i[0] == 1'b0) begin
        if ({r_id[i], r_co[i], r_sum[i]} !== {1'b0, 1'b0, 8'h46}) begin
          n_err++; $display("FAIL arb_result%0d: id=%b co=%b sum=%h required id=0 co=0 sum=46", i, r_id[i], r_co[i], r_sum[i]);
        end
      end else begin
        if ({r_id[i], r_co[i], r_sum[i]} !== {1'b1, 1'b1, 8'h11}) begin
          n_err++; $display("FAIL arb_result%0d: id=%b co=%b sum=%h required id=1 co=1 sum=11", i, r_id[i], r_co[i], r_sum[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure_reset();
    logic [W-1:0] s; bit co, rid, tmo, seen_valid; int lat, fac;
    run_op(1'b0, 8'h21, 8'h13, 1'b0, 1'b0, s, co, rid, lat, fac, tmo);
    n_vec++;
    if (tmo !== 1'b0 || {co, s, rid} !== {1'b0, 8'h34, 1'b0}) begin
      n_err++; $display("FAIL bp_result: tmo=%b co=%b sum=%h id=%b required co=0 sum=34 id=0", tmo, co, s, rid);
    end
    // A pending request must not be taken while the result is held.
    bus.req1_valid = 1'b1; bus.req1_a = 8'h01; bus.req1_b = 8'h02; bus.req1_ci = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk); #1;
      n_vec++;
      if ({bus.res_valid, bus.res_co, bus.res_sum, bus.res_id, bus.req0_ready, bus.req1_ready}
          !== {1'b1, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL bp_hold%0d: valid=%b co=%b sum=%h id=%b rdy=%b%b required valid=1 co=0 sum=34 id=0 rdy=00",
                          i, bus.res_valid, bus.res_co, bus.res_sum, bus.res_id, bus.req0_ready, bus.req1_ready);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.res_valid, bus.busy} !== 2'b00) begin
      n_err++; $display("FAIL bp_release: valid=%b busy=%b required 00", bus.res_valid, bus.busy);
    end
    // Reset while cnt==3.
    bus.req0_valid = 1'b1; bus.req0_a = 8'hAA; bus.req0_b = 8'h55; bus.req0_ci = 1'b0;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.res_valid} !== 2'b00) begin
      n_err++; $display("FAIL rst_run_idle: busy=%b valid=%b required 00", bus.busy, bus.res_valid);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen_valid = 1'b1;
    end
    n_vec++;
    if (seen_valid !== 1'b0) begin n_err++; $display("FAIL rst_run_no_result: seen=%b required 0", seen_valid); end
    run_op(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, s, co, rid, lat, fac, tmo);
    n_vec++;
    if (tmo !== 1'b0 || {co, s, rid} !== {1'b0, 8'h02, 1'b0}) begin
      n_err++; $display("FAIL rst_run_next: tmo=%b co=%b sum=%h id=%b required co=0 sum=02 id=0", tmo, co, s, rid);
    end
    take_result();
  endtask

`ifdef SERIAL_FA_SCHED_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s; bit co, rid, tmo; int lat, fac;
    run_op(1'b0, 8'h10, 8'h01, 1'b0, 1'b1, s, co, rid, lat, fac, tmo);
    n_vec++;
    if (tmo !== 1'b0 || {co, s} !== {1'b1, 8'h0F}) begin
      n_err++; $display("FAIL sub_10_01: tmo=%b co=%b diff=%h required co=1 diff=0f", tmo, co, s);
    end
    take_result();
    run_op(1'b1, 8'h00, 8'h01, 1'b1, 1'b1, s, co, rid, lat, fac, tmo);
    n_vec++;
    if (tmo !== 1'b0 || {co, s} !== {1'b0, 8'hFF}) begin
      n_err++; $display("FAIL sub_00_01: tmo=%b co=%b diff=%h required co=0 diff=ff", tmo, co, s);
    end
    take_result();
  endtask
`endif

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ci = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ci = 1'b0;
    bus.res_ready  = 1'b0;
`ifdef SERIAL_FA_SCHED_SUB_EN
    bus.req0_sub = 1'b0; bus.req1_sub = 1'b0;
`endif
    test_reset();
    test_single_add();
    test_carry();
    test_arbitration();
    test_backpressure_reset();
`ifdef SERIAL_FA_SCHED_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end
endmodule
